// File: rtl/cpu_pause_pkg.sv
// Shared definitions for the CPU pause gate: FSM state encoding and defaults.
package cpu_pause_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_PAUSED = 2'd2,
        ST_STEP   = 2'd3
    } state_t;

    // Longest drain (in ce pulses) before the gate forces the CPU to stop.
    localparam int unsigned WAIT_MAX_DEFAULT = 65535;
    // Drain counter width; must be able to hold WAIT_MAX.
    localparam int unsigned CW_DEFAULT       = 16;

endpackage

// File: rtl/cpu_pause_gate_rise_edge.sv
// One-bit rising-edge detector: remembers last cycle's level, flags 0->1.
module rise_edge (
    input  logic clk,
    input  logic srst,
    input  logic d_i,
    output logic rise_o
);

    logic last_q;

    // Track the previous level of the input.
    always_ff @(posedge clk) begin
        if (srst) begin
            last_q <= 1'b0;
        end else begin
            last_q <= d_i;
        end
    end

    assign rise_o = d_i & ~last_q;

endmodule

// File: rtl/cpu_pause_gate.sv
// Gates the CPU clock-enable so a pause request freezes the CPU only at an
// opcode fetch (optionally inside vblank), acknowledges the freeze, supports
// single-instruction stepping and forces a stop after WAIT_MAX drained pulses.
module cpu_pause_gate
    import cpu_pause_pkg::*;
#(
    parameter bit          SYNC_VBLANK = 1'b0,
    parameter int unsigned WAIT_MAX    = WAIT_MAX_DEFAULT,
    parameter int unsigned CW          = CW_DEFAULT
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic pause_cpu,
    input  logic step_button,
    input  logic cpu_ce_in,
    input  logic cpu_m1_n,
    input  logic vblank,
    output logic cpu_ce_out,
    output logic paused,
    output logic timeout
);

    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(WAIT_MAX);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          paused_q;
    logic          timeout_q;
    logic          seen_fetch_end_q;

    logic          step_edge;
    logic          safe;
    logic          natural_exit;
    logic          forced_exit;
    logic          exit_pulse;

    // Step requests are only acted on while frozen; edges elsewhere just fall away.
    rise_edge u_step_edge (
        .clk    (clk_sys),
        .srst   (reset),
        .d_i    (step_button),
        .rise_o (step_edge)
    );

    // Decide whether the current ce pulse is the one that freezes the CPU.
    always_comb begin
        safe         = cpu_ce_in & ~cpu_m1_n & (SYNC_VBLANK ? vblank : 1'b1);
        natural_exit = 1'b0;
        forced_exit  = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                natural_exit = pause_cpu & safe;
            end
            ST_DRAIN: begin
                natural_exit = pause_cpu & safe;
                forced_exit  = pause_cpu & ~safe & cpu_ce_in & (cnt_q == CNT_LAST);
            end
            ST_STEP: begin
                // Must first leave the fetch that was frozen, then stop at the next one.
                natural_exit = pause_cpu & seen_fetch_end_q & safe;
                forced_exit  = pause_cpu & ~natural_exit & cpu_ce_in & (cnt_q == CNT_LAST);
            end
            default: begin
            end
        endcase
        exit_pulse = natural_exit | forced_exit;
    end

    // Zero-latency ce gating; reset lets the raw enable straight through.
    always_comb begin
        if (reset) begin
            cpu_ce_out = cpu_ce_in;
        end else if (state_q == ST_PAUSED) begin
            cpu_ce_out = 1'b0;
        end else begin
            cpu_ce_out = cpu_ce_in & ~exit_pulse;
        end
    end

    // Pause handshake FSM with registered acknowledge and timeout flag.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q          <= ST_RUN;
            cnt_q            <= '0;
            paused_q         <= 1'b0;
            timeout_q        <= 1'b0;
            seen_fetch_end_q <= 1'b0;
        end else begin
            paused_q <= (state_q == ST_PAUSED);
            unique case (state_q)
                ST_RUN: begin
                    if (pause_cpu) begin
                        if (natural_exit) begin
                            state_q   <= ST_PAUSED;
                            timeout_q <= 1'b0;
                        end else begin
                            state_q <= ST_DRAIN;
                            cnt_q   <= '0;
                        end
                    end
                end
                ST_DRAIN, ST_STEP: begin
                    if (!pause_cpu) begin
                        state_q <= ST_RUN;
                    end else if (exit_pulse) begin
                        state_q   <= ST_PAUSED;
                        timeout_q <= forced_exit;
                    end else begin
                        if (cpu_ce_in && (cnt_q != CNT_MAX)) begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                        if ((state_q == ST_STEP) && cpu_ce_in && cpu_m1_n) begin
                            seen_fetch_end_q <= 1'b1;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (!pause_cpu) begin
                        state_q <= ST_RUN;
                    end else if (step_edge) begin
                        state_q          <= ST_STEP;
                        cnt_q            <= '0;
                        seen_fetch_end_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    assign paused  = paused_q;
    assign timeout = timeout_q;

endmodule
